// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 8-digit 7-segment scan controller.
package seven_seg_pkg;

  // Cathode and anode idle levels (active-low display: all ones is dark).
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [7:0] AN_ALL_OFF = 8'hFF;

  // Active-low segment patterns {CG,CF,CE,CD,CC,CB,CA}, indexed by hex nibble.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Phase within a digit slot.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  // Width of the slot counter that runs 0..clks-1.
  function automatic int unsigned cnt_width(input int unsigned clks);
    return (clks > 2) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_hex.sv
// Purely combinational hex nibble to active-low segment decode.
module hex_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one hex digit.
  always_comb begin
    seg = HEX_SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// Display data arrives through a single-entry valid/ready buffer and is
// committed to the active registers only at the end of digit 7's slot.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned CLKS_PER_DIGIT = 100000,
  parameter int unsigned BLANK_CYCLES   = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_value,
  input  logic [7:0]  load_digit_en,
  input  logic [7:0]  load_dp,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frame_start,
  output logic [2:0]  cur_digit
);

  localparam int unsigned     CNT_W    = cnt_width(CLKS_PER_DIGIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
  // Phase of slot position 0; with no blanking every cycle is a drive cycle.
  localparam phase_e PHASE_AT_ZERO = (BLANK_CYCLES == 0) ? PH_DRIVE : PH_BLANK;

  // Scan state
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  phase_e           phase, phase_d;
  logic             slot_last;
  logic             commit;

  // Active and pending display data
  logic [31:0] act_value, pend_value;
  logic [7:0]  act_en, pend_en;
  logic [7:0]  act_dp, pend_dp;
  logic        pend_full;

  // Output datapath
  logic [3:0] nibble;
  logic [6:0] seg_dec;
  logic       lit;
  logic [7:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  // Scan state register: slot counter, digit index and slot phase.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt   <= '0;
      idx   <= '0;
      phase <= PHASE_AT_ZERO;
    end else begin
      cnt   <= cnt_d;
      idx   <= idx_d;
      phase <= phase_d;
    end
  end

  // Next scan state; phase is decoded from the next count so it stays
  // aligned with cnt in the register.
  always_comb begin
    slot_last = (cnt == CNT_LAST);
    cnt_d     = cnt + 1'b1;
    idx_d     = idx;
    if (slot_last) begin
      cnt_d = '0;
      idx_d = idx + 3'd1;
    end
    phase_d = (32'(cnt_d) < BLANK_CYCLES) ? PH_BLANK : PH_DRIVE;
    commit  = slot_last && (idx == 3'd7);
  end

  // Pending buffer capture and frame-boundary commit to the active set.
  // A full buffer at the commit cycle empties, so a load waiting on it
  // is taken one cycle later once load_ready has risen.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pend_full  <= 1'b0;
      pend_value <= '0;
      pend_en    <= '0;
      pend_dp    <= '0;
      act_value  <= '0;
      act_en     <= '0;
      act_dp     <= '0;
    end else if (commit && pend_full) begin
      act_value <= pend_value;
      act_en    <= pend_en;
      act_dp    <= pend_dp;
      pend_full <= 1'b0;
    end else if (load_valid && !pend_full) begin
      pend_value <= load_value;
      pend_en    <= load_digit_en;
      pend_dp    <= load_dp;
      pend_full  <= 1'b1;
    end
  end

  assign load_ready = ~pend_full;

  // Select the current digit's nibble and decide whether it is lit.
  always_comb begin
    nibble = act_value[{idx, 2'b00} +: 4];
    lit    = (phase == PH_DRIVE) && act_en[idx];
    an_d   = AN_ALL_OFF;
    seg_d  = SEG_BLANK;
    dp_d   = 1'b1;
    if (lit) begin
      an_d  = ~(8'b0000_0001 << idx);
      seg_d = seg_dec;
      dp_d  = ~act_dp[idx];
    end
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // Registered pin outputs, one cycle behind the scan state.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      AN          <= AN_ALL_OFF;
      SEG         <= SEG_BLANK;
      DP          <= 1'b1;
      frame_start <= 1'b0;
      cur_digit   <= '0;
    end else begin
      AN          <= an_d;
      SEG         <= seg_d;
      DP          <= dp_d;
      frame_start <= (cnt == '0) && (idx == 3'd0);
      cur_digit   <= idx;
    end
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display. It holds a 32-bit hex display word plus per-digit enable and decimal-point masks, and sequences AN[7:0] and the cathodes one digit at a time. It inserts a blanking gap between digits to prevent ghosting. New display data is accepted through a valid/ready handshake and committed only at frame boundaries, so the display never tears. It sits between the counting/datapath logic and the physical AN/CA..CG/DP pins.

Parameters:
CLKS_PER_DIGIT, 100000, clock cycles per digit slot (1 kHz slot, 125 Hz frame at 100 MHz); must be >= 2.
BLANK_CYCLES, 1000, leading cycles of each slot with all anodes off; legal range is 0 to CLKS_PER_DIGIT-1.

Ports:
CLK100MHZ  in  1  system clock.
CPU_RESETN  in  1  asynchronous reset, active-low.
load_valid  in  1  new display data offered.
load_ready  out  1  pending buffer empty; a load is accepted when load_valid && load_ready.
load_value  in  32  hex nibbles; nibble k (bits 4k+3:4k) drives digit k.
load_digit_en  in  8  per-digit enable; 0 means the digit stays dark.
load_dp  in  8  per-digit decimal point; 1 means lit.
AN  out  8  anodes, active-low; at most one bit is low at a time.
SEG  out  7  cathodes {CG,CF,CE,CD,CC,CB,CA}, active-low.
DP  out  1  decimal-point cathode, active-low.
frame_start  out  1  one-cycle pulse at the start of the digit-0 slot.
cur_digit  out  3  index of the current slot.

Behaviour:
- Reset (async assert, sync release) sets every output immediately:
  - AN=8'hFF, SEG=7'h7F, DP=1, frame_start=0, cur_digit=0, load_ready=1.
  - Internal state: slot counter cnt=0, idx=0, active value/enable/dp all 0, pending buffer empty.
- Slot counter cnt runs 0..CLKS_PER_DIGIT-1 and wraps. At wrap, idx increments modulo 8 (7 wraps to 0).
- Phase within a slot:
  - BLANK while cnt < BLANK_CYCLES.
  - DRIVE otherwise.
- Outputs are registered, so they reflect the cnt/idx of the previous cycle (1-cycle latency).
- During DRIVE with active_en[idx]=1:
  - AN = ~(1<<idx).
  - SEG = hex pattern of active nibble idx.
  - DP = ~active_dp[idx].
- During BLANK, or when active_en[idx]=0: AN=8'hFF, SEG=7'h7F, DP=1. A disabled digit still consumes its slot, so brightness stays constant.
- Hex patterns (SEG):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Handshake:
  - On load_valid && load_ready, the pending buffer captures {value, en, dp} and load_ready drops next cycle.
  - load_valid while load_ready=0 is ignored; the source must hold it.
- Commit happens in the cycle where cnt==CLKS_PER_DIGIT-1 and idx==7. If the pending buffer is full, active takes pending and pending empties, so load_ready=1 next cycle.
- Load and commit in the same cycle:
  - Pending empty: the load goes to pending and commits at the next frame.
  - Pending full: the commit happens and load_ready is still 0, so the load is accepted the cycle after.
- frame_start is high for exactly one cycle, aligned with the first output cycle of slot idx=0.
- cur_digit equals the idx that AN is currently showing (or blanking).
- Reset mid-slot blanks the display at once; scanning restarts from digit 0 and any pending data is discarded.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16-entry active-low hex segment table;
  - SEG_BLANK=7'h7F and AN_ALL_OFF=8'hFF;
  - a localparam helper for the counter width, $clog2(CLKS_PER_DIGIT).
- Sub-module hex_to_7seg: purely combinational nibble-to-SEG decode, instantiated once on the muxed nibble.
- Top-level seven_seg_scan_ctrl holds the counter, scan FSM, handshake buffer and output registers.

Test Plan:
(All tests use CLKS_PER_DIGIT=8, BLANK_CYCLES=2.)
1. Reset, then 64 cycles with no load -> AN stays 8'hFF, SEG stays 7'h7F, DP stays 1; frame_start pulses every 64 cycles; cur_digit steps 0..7.
2. Load value=32'h7654_3210, en=8'hFF, dp=8'h01 -> after the next commit, each slot shows 2 cycles blank then 6 cycles of AN=~(1<<k) with nibble k's pattern; SEG=1000000 and DP=0 only in slot 0.
3. Load en=8'h0F with value=32'h8888_8888 -> slots 4..7 keep AN=8'hFF; slots 0..3 show SEG=0000000.
4. Back-to-back loads A then B with load_valid held -> B's load_ready stays 0 until A commits; A is displayed for exactly one full frame, then B.
5. Load asserted in the commit cycle with pending empty -> the data is not shown in the immediately following frame, only in the one after.
6. Assert CPU_RESETN=0 during the DRIVE phase of slot 5 -> AN=8'hFF with no clock edge needed; after release, scanning resumes at cur_digit=0 with a blank display and load_ready=1.
